acc_rmw_writer: RTL
===================

Name: acc_rmw_writer

Overview:
- Upstream write stage of the double-buffered accumulator memory (256 x 64-bit entries, two signed 32-bit column lanes per entry).
- Takes partial-sum vectors from the systolic array drain.
- Per element, either overwrites the addressed entry or adds into it by read-modify-write over the accumulator's read and write ports.
- Hides the memory's 1-cycle registered read latency with a 2-stage pipeline and a single-entry write-forwarding register.

Parameters:
- LANE_W, 32, width of one column lane; entry width is 2*LANE_W.
- ADDR_W, 8, accumulator address width.
- SATURATE, 0, 0 = wrap-around lane add, 1 = signed saturating lane add.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts element this cycle.
- in_addr  in  ADDR_W  target entry address.
- in_data  in  2*LANE_W  partial sums; bits [LANE_W-1:0] = col0, upper lane = col1.
- in_accum  in  1  1 = add to existing entry, 0 = overwrite.
- enable  in  1  allows acceptance; deasserted by the controller before a buffer swap or clear.
- acc_rd_en  out  1  accumulator read enable.
- acc_rd_addr  out  ADDR_W  accumulator read address.
- acc_rd_data  in  2*LANE_W  accumulator registered read data, valid 1 cycle after acc_rd_en.
- acc_wr_en  out  1  accumulator write enable.
- acc_wr_addr  out  ADDR_W  accumulator write address.
- acc_wr_data  out  2*LANE_W  accumulator write data.
- idle  out  1  both pipeline stages empty.
- ovf_flag  out  1  sticky saturation event; only when SATURATE=1, tied 0 otherwise.
- ovf_clr  in  1  clears ovf_flag.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n).
  - On a clk edge with rst_n=0: S1 valid, fwd_valid and ovf_flag all clear.
  - While rst_n is low, in_ready=0.
  - From the first edge with rst_n=1: acc_rd_en=0, acc_wr_en=0, idle=1, and both address ports and acc_wr_data read 0.
  - Reset mid-operation drops in-flight elements; no partial write is issued after reset.
- Acceptance: in_ready = enable. An element is accepted when in_valid && in_ready. There is no downstream backpressure.
- S0 (accept cycle, combinational):
  - acc_rd_en = accepted && in_accum.
  - acc_rd_addr = in_addr.
  - At the edge, S1 captures valid, addr, data and accum.
- S1 (next cycle):
  - base is chosen by priority:
    1. 0 if !accum.
    2. Otherwise fwd_data if fwd_valid && fwd_addr == S1.addr.
    3. Otherwise acc_rd_data.
  - Each lane's result = base lane + S1.data lane.
  - acc_wr_en = S1.valid, acc_wr_addr = S1.addr, acc_wr_data = result.
  - Latency is fixed: the write occurs exactly 1 cycle after acceptance. Throughput is 1 element per cycle.
- Forwarding register:
  - At every edge, fwd_valid <= S1.valid, fwd_addr <= S1.addr, fwd_data <= result.
  - Needed because the memory samples a read and a write on the same edge and returns the old value. Only the immediately preceding write can be stale; older writes are already in memory.
- Back-to-back same address (A at t, A at t+1, both accum): the second add uses the first result through forwarding, never the stale memory value.
- Overwrite followed by accum on the same address: forwarding applies identically.
- enable low:
  - Accepts nothing.
  - In-flight S1 still writes.
  - fwd_valid clears at the edge where S1 is empty. This guarantees no forwarding across a buffer swap or clear, which are issued only while idle=1.
- idle = !S1.valid.
- Arithmetic:
  - Lanes are independent and signed two's complement; there is no carry between lanes.
  - SATURATE=0: result wraps modulo 2^LANE_W.
  - SATURATE=1: a result above max clamps to 0x7FFFFFFF and one below min clamps to 0x80000000; any lane clamp sets ovf_flag.
  - If ovf_clr and a new clamp occur in the same cycle, set wins.

Decomposition:
- Shared package (tpu_acc_pkg): ACC_ADDR_W=8, ACC_LANE_W=32, ACC_ENTRY_W=64, an acc_entry_t packed struct {col1, col0}, and lane max/min constants.
- Sub-module lane_adder holds one lane's add, wrap or saturate logic and overflow flag; it is instantiated twice.

Test Plan:
- Overwrite: in_accum=0, addr 0x05, data {col1 7, col0 3} -> acc_wr_en 1 cycle later, wr_data {7,3}; acc_rd_en stays 0.
- Accumulate from memory: memory[0x10]={100,-50}; accum with {1,2} -> acc_rd_en with addr 0x10 on the accept cycle, then write {101,-48} the next cycle.
- Back-to-back hazard: three consecutive accum writes of {1,1} to 0x20, starting from {0,0} -> writes {1,1}, {2,2}, {3,3}. With forwarding disabled the bench must flag the failure.
- Interleaved addresses: 0x30, 0x31, 0x30 accum with {1,0} each -> 0x30 ends at {2,0} and is read from memory, not forwarded.
- Saturation (SATURATE=1): memory {0x7FFFFFF0, 0x80000005} + {0x20, -0x10} -> write {0x7FFFFFFF, 0x80000000}; ovf_flag=1 until ovf_clr.
- Control: enable drop with S1 full -> pending write completes, idle=1 the next cycle. Reset asserted with S1 full -> no acc_wr_en after reset; all outputs 0.

Source files
------------

// File: rtl/tpu_acc_pkg.sv
// rtl/tpu_acc_pkg.sv - shared accumulator-memory types and constants
//
// Purpose: geometry of the double-buffered accumulator memory (256 x 64-bit
// entries, two signed 32-bit column lanes per entry) and the lane limits used
// by the saturating adder.
// Ports: none (package).

package tpu_acc_pkg;

  localparam int ACC_ADDR_W  = 8;
  localparam int ACC_LANE_W  = 32;
  localparam int ACC_ENTRY_W = 2 * ACC_LANE_W;

  // col0 occupies the low lane, col1 the high lane.
  typedef struct packed {
    logic [ACC_LANE_W-1:0] col1;
    logic [ACC_LANE_W-1:0] col0;
  } acc_entry_t;

  localparam logic [ACC_LANE_W-1:0] ACC_LANE_MAX = {1'b0, {(ACC_LANE_W-1){1'b1}}};
  localparam logic [ACC_LANE_W-1:0] ACC_LANE_MIN = {1'b1, {(ACC_LANE_W-1){1'b0}}};

endpackage

// File: rtl/lane_adder.sv
// rtl/lane_adder.sv - one signed column-lane adder, wrapping or saturating
//
// Purpose: adds two signed two's-complement lanes. With SATURATE=0 the sum
// wraps modulo 2^LANE_W; with SATURATE=1 it clamps to the lane max/min and
// reports the clamp.
// Ports:
//   a_i     in  LANE_W  base lane (memory, forwarded, or zero)
//   b_i     in  LANE_W  incoming partial-sum lane
//   sum_o   out LANE_W  lane result
//   clamp_o out 1       result was clamped (always 0 when SATURATE=0)

module lane_adder
  import tpu_acc_pkg::*;
#(
  parameter int LANE_W   = ACC_LANE_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output logic [LANE_W-1:0] sum_o,
  output logic              clamp_o
);

  localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  generate
    if (SATURATE) begin : g_sat
      logic [LANE_W:0] wide;
      logic            ovf;

      // One guard bit: the true sign is wide[LANE_W]; a mismatch with the
      // lane sign bit means the LANE_W-bit result overflowed.
      assign wide = {a_i[LANE_W-1], a_i} + {b_i[LANE_W-1], b_i};
      assign ovf  = wide[LANE_W] ^ wide[LANE_W-1];

      always_comb begin
        sum_o = wide[LANE_W-1:0];
        if (ovf) begin
          sum_o = wide[LANE_W] ? LANE_MIN : LANE_MAX;
        end
      end
      assign clamp_o = ovf;
    end else begin : g_wrap
      assign sum_o   = a_i + b_i;
      assign clamp_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/acc_rmw_writer.sv
// rtl/acc_rmw_writer.sv - accumulator write stage with read-modify-write
//
// Purpose: accepts partial-sum vectors from the systolic drain and either
// overwrites or adds into the addressed accumulator entry. S0 issues the
// memory read on the accept cycle; S1 forms the sum one cycle later when the
// registered read data arrives and issues the write. A single forwarding
// register covers the one write the memory cannot yet reflect.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   element handshake (in_ready = enable)
//   in_addr/in_data     target entry and partial sums {col1, col0}
//   in_accum            1 = add into entry, 0 = overwrite
//   enable              acceptance gate from the buffer controller
//   acc_rd_en/addr/data accumulator read port (data 1 cycle after enable)
//   acc_wr_en/addr/data accumulator write port
//   idle                no element in S1
//   ovf_flag/ovf_clr    sticky saturation event and its clear

module acc_rmw_writer
  import tpu_acc_pkg::*;
#(
  parameter int LANE_W   = ACC_LANE_W,
  parameter int ADDR_W   = ACC_ADDR_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [2*LANE_W-1:0] in_data,
  input  logic                in_accum,
  input  logic                enable,
  output logic                acc_rd_en,
  output logic [ADDR_W-1:0]   acc_rd_addr,
  input  logic [2*LANE_W-1:0] acc_rd_data,
  output logic                acc_wr_en,
  output logic [ADDR_W-1:0]   acc_wr_addr,
  output logic [2*LANE_W-1:0] acc_wr_data,
  output logic                idle,
  output logic                ovf_flag,
  input  logic                ovf_clr
);

  localparam int ENTRY_W = 2 * LANE_W;

  // S1 stage
  logic                s1_valid_q, s1_valid_d;
  logic                s1_accum_q, s1_accum_d;
  logic [ADDR_W-1:0]   s1_addr_q,  s1_addr_d;
  logic [ENTRY_W-1:0]  s1_data_q,  s1_data_d;

  // Forwarding register: the write committed on the previous edge
  logic                fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0]   fwd_addr_q,  fwd_addr_d;
  logic [ENTRY_W-1:0]  fwd_data_q,  fwd_data_d;

  logic                ovf_q, ovf_d;

  logic                accept;
  logic [ENTRY_W-1:0]  base;
  logic [ENTRY_W-1:0]  result;
  logic                clamp0, clamp1;
  logic                clamp_any;

  // ---------------- S0: accept and issue read ----------------
  // in_ready is held low during reset so nothing is captured on a reset edge.
  assign in_ready    = enable && rst_n;
  assign accept      = in_valid && in_ready;
  assign acc_rd_en   = accept && in_accum;
  assign acc_rd_addr = acc_rd_en ? in_addr : '0;

  // ---------------- S1: select base, add, write ----------------
  // The memory returns the pre-write value when a read and a write to the
  // same entry share an edge, so the immediately preceding result must be
  // taken from the forwarding register instead.
  always_comb begin
    base = acc_rd_data;
    if (!s1_accum_q) begin
      base = '0;
    end else if (fwd_valid_q && (fwd_addr_q == s1_addr_q)) begin
      base = fwd_data_q;
    end
  end

  lane_adder #(
    .LANE_W   (LANE_W),
    .SATURATE (SATURATE)
  ) u_lane0 (
    .a_i     (base[LANE_W-1:0]),
    .b_i     (s1_data_q[LANE_W-1:0]),
    .sum_o   (result[LANE_W-1:0]),
    .clamp_o (clamp0)
  );

  lane_adder #(
    .LANE_W   (LANE_W),
    .SATURATE (SATURATE)
  ) u_lane1 (
    .a_i     (base[ENTRY_W-1:LANE_W]),
    .b_i     (s1_data_q[ENTRY_W-1:LANE_W]),
    .sum_o   (result[ENTRY_W-1:LANE_W]),
    .clamp_o (clamp1)
  );

  // Write-port fields are zeroed when S1 is empty so an idle port is quiet.
  assign acc_wr_en   = s1_valid_q;
  assign acc_wr_addr = s1_valid_q ? s1_addr_q : '0;
  assign acc_wr_data = s1_valid_q ? result    : '0;
  assign idle        = !s1_valid_q;

  assign clamp_any   = s1_valid_q && (clamp0 || clamp1);

  // ---------------- next state ----------------
  always_comb begin
    s1_valid_d  = accept;
    s1_accum_d  = s1_accum_q;
    s1_addr_d   = s1_addr_q;
    s1_data_d   = s1_data_q;
    if (accept) begin
      s1_accum_d = in_accum;
      s1_addr_d  = in_addr;
      s1_data_d  = in_data;
    end

    // fwd_valid follows S1 valid, so one empty S1 cycle (enable low before a
    // swap or clear) is enough to stop any forwarding across it.
    fwd_valid_d = s1_valid_q;
    fwd_addr_d  = s1_addr_q;
    fwd_data_d  = result;

    // A clamp in the same cycle as ovf_clr keeps the flag set.
    ovf_d = (ovf_q && !ovf_clr) || clamp_any;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_accum_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_accum_q  <= s1_accum_d;
      s1_addr_q   <= s1_addr_d;
      s1_data_q   <= s1_data_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      ovf_q       <= ovf_d;
    end
  end

  // Without saturation there is no clamp event; the flag is tied off.
  assign ovf_flag = SATURATE ? ovf_q : 1'b0;

endmodule
